// File: rtl/delta_pe_stream.sv
// rtl/delta_pe_stream.sv - delta processing element with valid/ready output scatter stream
//
// Per accepted job: one full product (in_val * in_weight), then one output write per
// kernel entry, the partial product updated by signed power-of-two deltas between writes.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     job handshake; in_ready is high only while idle
//   in_val, in_weight     signed activation and base weight
//   in_h, in_w            activation row/col
//   in_count              number of entries in this job (0..NUM_ENTRIES)
//   in_entries            packed entries {skip,neg,shift,ch,kh,kw}, entry 0 at LSBs
//   out_valid/out_ready   scatter-write handshake
//   out_val               partial product for the current entry
//   out_ch, out_h, out_w  scatter-write address
//   overflow              sticky per job, set on any signed add overflow
//   done                  one-cycle pulse in the first idle cycle after a job
module delta_pe_stream #(
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 24,
  parameter int NUM_ENTRIES = 16,
  parameter int SHIFT_W     = 4,
  parameter int CH_W        = 4,
  parameter int KH_W        = 2,
  parameter int KW_W        = 2,
  parameter int H_W         = 6,
  parameter int W_W         = 6,
  parameter int OUT_H       = 32,
  parameter int OUT_W       = 32,
  parameter int SATURATE    = 0,
  localparam int ENTRY_W    = 2 + SHIFT_W + CH_W + KH_W + KW_W,
  localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_val,
  input  logic signed [DATA_W-1:0]       in_weight,
  input  logic [H_W-1:0]                 in_h,
  input  logic [W_W-1:0]                 in_w,
  input  logic [CNT_W-1:0]               in_count,
  input  logic [NUM_ENTRIES*ENTRY_W-1:0] in_entries,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [ACC_W-1:0]        out_val,
  output logic [CH_W-1:0]                out_ch,
  output logic [H_W-1:0]                 out_h,
  output logic [W_W-1:0]                 out_w,
  output logic                           overflow,
  output logic                           done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;

  localparam int ADDR_W  = CH_W + KH_W + KW_W;
  localparam int DELTA_W = 2 + SHIFT_W;
  localparam int IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  // One extra bit so an underflowing subtraction lands above the limit as well.
  localparam logic [H_W:0] H_LIM = (H_W+1)'(OUT_H);
  localparam logic [W_W:0] W_LIM = (W_W+1)'(OUT_W);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] val_q, weight_q;
  logic [H_W-1:0]           h_q;
  logic [W_W-1:0]           w_q;
  logic [CNT_W-1:0]         count_q;
  logic [IDX_W-1:0]         idx, idx_nxt;
  // Address fields and delta fields kept apart: the address comes from entry idx,
  // the delta applied on advance comes from entry idx+1.
  logic [ADDR_W-1:0]        addr_mem  [NUM_ENTRIES];
  logic [DELTA_W-1:0]       delta_mem [NUM_ENTRIES];

  logic [ADDR_W-1:0]        cur_addr;
  logic [DELTA_W-1:0]       nxt_delta;
  logic [H_W:0]             h_diff;
  logic [W_W:0]             w_diff;
  logic                     suppressed, last, add_ovf;
  logic signed [ACC_W-1:0]  act_ext, wgt_ext, product, term, sum_raw, sum_next;

  assign idx_nxt   = idx + IDX_W'(1);
  assign cur_addr  = addr_mem[idx];
  assign nxt_delta = delta_mem[idx_nxt];
  assign act_ext   = ACC_W'(val_q);
  assign wgt_ext   = ACC_W'(weight_q);
  assign product   = act_ext * wgt_ext;
  assign last      = (CNT_W'(idx) + CNT_W'(1)) == count_q;

  assign h_diff     = {1'b0, h_q} - (H_W+1)'(cur_addr[KW_W +: KH_W]);
  assign w_diff     = {1'b0, w_q} - (W_W+1)'(cur_addr[KW_W-1:0]);
  assign suppressed = (h_diff >= H_LIM) || (w_diff >= W_LIM);

  always_comb begin
    term = act_ext <<< nxt_delta[SHIFT_W-1:0];
    if (nxt_delta[SHIFT_W])
      term = -term;
    if (nxt_delta[SHIFT_W+1])
      term = '0;
    sum_raw  = out_val + term;
    add_ovf  = (out_val[ACC_W-1] == term[ACC_W-1]) && (sum_raw[ACC_W-1] != out_val[ACC_W-1]);
    sum_next = sum_raw;
    if (add_ovf && (SATURATE != 0))
      sum_next = out_val[ACC_W-1] ? ACC_MIN : ACC_MAX;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT) && !suppressed;
  assign out_ch    = (state == EMIT) ? cur_addr[KW_W+KH_W +: CH_W] : '0;
  assign out_h     = (state == EMIT) ? h_diff[H_W-1:0] : '0;
  assign out_w     = (state == EMIT) ? w_diff[W_W-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      val_q    <= '0;
      weight_q <= '0;
      h_q      <= '0;
      w_q      <= '0;
      count_q  <= '0;
      idx      <= '0;
      out_val  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        addr_mem[k]  <= '0;
        delta_mem[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            val_q    <= in_val;
            weight_q <= in_weight;
            h_q      <= in_h;
            w_q      <= in_w;
            count_q  <= in_count;
            overflow <= 1'b0;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
              addr_mem[k]  <= in_entries[k*ENTRY_W +: ADDR_W];
              delta_mem[k] <= in_entries[k*ENTRY_W + ADDR_W +: DELTA_W];
            end
            state <= MULT;
          end
        end
        MULT: begin
          out_val <= product;
          idx     <= '0;
          if (count_q == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: begin
          // Suppressed entries have out_valid low, so they move on without a handshake.
          if (out_ready || suppressed) begin
            if (last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              idx     <= idx_nxt;
              out_val <= sum_next;
              if (add_ovf)
                overflow <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_pe_stream.sv
// tb/tb_delta_pe_stream.sv - directed self-checking bench for delta_pe_stream
module tb_delta_pe_stream;

  localparam int NE = 16;
  localparam int EW = 14;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset, in_valid, out_ready;
  logic signed [7:0]    in_val, in_weight;
  logic [5:0]           in_h, in_w;
  logic [4:0]           in_count;
  logic [NE*EW-1:0]     in_entries;

  // default configuration (ACC_W=24, wrap)
  logic                 in_ready, out_valid, overflow, done;
  logic signed [23:0]   out_val;
  logic [3:0]           out_ch;
  logic [5:0]           out_h, out_w;
  // ACC_W=16, saturating
  logic                 s1_ready, s1_valid, s1_ovf, s1_done;
  logic signed [15:0]   s1_val;
  logic [3:0]           s1_ch;
  logic [5:0]           s1_h, s1_w;
  // ACC_W=16, wrapping
  logic                 s0_ready, s0_valid, s0_ovf, s0_done;
  logic signed [15:0]   s0_val;
  logic [3:0]           s0_ch;
  logic [5:0]           s0_h, s0_w;

  int n_assert = 0;
  int n_fail   = 0;

  delta_pe_stream dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_weight(in_weight), .in_h(in_h), .in_w(in_w),
    .in_count(in_count), .in_entries(in_entries), .out_valid(out_valid),
    .out_ready(out_ready), .out_val(out_val), .out_ch(out_ch), .out_h(out_h),
    .out_w(out_w), .overflow(overflow), .done(done)
  );

  delta_pe_stream #(.ACC_W(16), .SATURATE(1)) dut_s1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s1_ready),
    .in_val(in_val), .in_weight(in_weight), .in_h(in_h), .in_w(in_w),
    .in_count(in_count), .in_entries(in_entries), .out_valid(s1_valid),
    .out_ready(out_ready), .out_val(s1_val), .out_ch(s1_ch), .out_h(s1_h),
    .out_w(s1_w), .overflow(s1_ovf), .done(s1_done)
  );

  delta_pe_stream #(.ACC_W(16), .SATURATE(0)) dut_s0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s0_ready),
    .in_val(in_val), .in_weight(in_weight), .in_h(in_h), .in_w(in_w),
    .in_count(in_count), .in_entries(in_entries), .out_valid(s0_valid),
    .out_ready(out_ready), .out_val(s0_val), .out_ch(s0_ch), .out_h(s0_h),
    .out_w(s0_w), .overflow(s0_ovf), .done(s0_done)
  );

  function automatic logic [EW-1:0] ent(input logic skip, input logic neg,
                                        input logic [3:0] sh, input logic [3:0] ch,
                                        input logic [1:0] kh, input logic [1:0] kw);
    return {skip, neg, sh, ch, kh, kw};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_emit(input string tag, input int v, input int ch, input int h, input int w);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_val"}, out_val, v);
    chk({tag, "_ch"}, out_ch, ch);
    chk({tag, "_h"}, out_h, h);
    chk({tag, "_w"}, out_w, w);
  endtask

  // Offer a job in the current cycle T; returns in cycle T+1 (MULT).
  task automatic start(input int v, input int wt, input int h, input int w, input int cnt);
    in_val    = 8'(v);
    in_weight = 8'(wt);
    in_h      = 6'(h);
    in_w      = 6'(w);
    in_count  = 5'(cnt);
    in_valid  = 1'b1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid  = 1'b0;
  endtask

  // 3*5 base, +3<<1, -3, skip; bp = cycles of out_ready low while entry 1 is shown.
  task automatic job1(input int bp);
    in_entries = '0;
    in_entries[0*EW +: EW] = ent(0, 0, 4'd0, 4'd1, 2'd0, 2'd0);
    in_entries[1*EW +: EW] = ent(0, 0, 4'd1, 4'd1, 2'd0, 2'd1);
    in_entries[2*EW +: EW] = ent(0, 1, 4'd0, 4'd1, 2'd1, 2'd0);
    in_entries[3*EW +: EW] = ent(1, 0, 4'd0, 4'd1, 2'd0, 2'd0);
    start(3, 5, 2, 2, 4);
    in_entries = '1;
    chk("j1_mult_valid", out_valid, 0);
    chk("j1_mult_ready", in_ready, 0);
    tick();
    chk_emit("j1_e0", 15, 1, 2, 2);
    tick();
    if (bp > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        chk_emit("j1_hold", 21, 1, 2, 1);
        tick();
      end
      out_ready = 1'b1;
    end
    chk_emit("j1_e1", 21, 1, 2, 1);
    tick();
    chk_emit("j1_e2", 18, 1, 1, 2);
    chk("j1_ovf", overflow, 0);
    tick();
    chk_emit("j1_e3", 18, 1, 2, 2);
    chk("j1_done_early", done, 0);
    tick();
    chk("j1_done", done, 1);
    chk("j1_ready", in_ready, 1);
    chk("j1_idle_valid", out_valid, 0);
    tick();
    chk("j1_done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_val = '0; in_weight = '0; in_h = '0; in_w = '0; in_count = '0; in_entries = '0;
    tick();
    tick();
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_val", out_val, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_h", out_h, 0);
    chk("rst_w", out_w, 0);
    reset = 1'b0;
    tick();

    job1(0);
    job1(3);

    // Boundary suppression: row underflow and column == OUT_W.
    in_entries = '0;
    in_entries[0*EW +: EW] = ent(0, 0, 4'd0, 4'd1, 2'd0, 2'd2);
    in_entries[1*EW +: EW] = ent(0, 0, 4'd1, 4'd1, 2'd1, 2'd2);
    in_entries[2*EW +: EW] = ent(0, 1, 4'd0, 4'd1, 2'd0, 2'd1);
    in_entries[3*EW +: EW] = ent(0, 0, 4'd0, 4'd1, 2'd0, 2'd2);
    start(3, 5, 0, 33, 4);
    tick();
    chk_emit("sup_e0", 15, 1, 0, 31);
    tick();
    chk("sup_e1_valid", out_valid, 0);
    chk("sup_e1_ready", in_ready, 0);
    tick();
    chk("sup_e2_valid", out_valid, 0);
    tick();
    chk_emit("sup_e3", 21, 1, 0, 31);
    tick();
    chk("sup_done", done, 1);
    tick();

    // Overflow: 127*127 then two +127<<7 terms.
    in_entries = '0;
    in_entries[0*EW +: EW] = ent(0, 0, 4'd0, 4'd0, 2'd0, 2'd0);
    in_entries[1*EW +: EW] = ent(0, 0, 4'd7, 4'd0, 2'd0, 2'd0);
    in_entries[2*EW +: EW] = ent(0, 0, 4'd7, 4'd0, 2'd0, 2'd0);
    start(127, 127, 2, 2, 3);
    tick();
    chk("sat_e0_s1", s1_val, 16129);
    chk("sat_e0_s0", s0_val, 16129);
    tick();
    chk("sat_e1_s1", s1_val, 32385);
    chk("sat_e1_s0", s0_val, 32385);
    chk("sat_e1_s1_ovf", s1_ovf, 0);
    tick();
    chk("sat_e2_s1", s1_val, 32767);
    chk("sat_e2_s1_ovf", s1_ovf, 1);
    chk("sat_e2_s0", s0_val, -16895);
    chk("sat_e2_s0_ovf", s0_ovf, 1);
    chk("sat_e2_wide", out_val, 48641);
    chk("sat_e2_wide_ovf", overflow, 0);
    tick();
    chk("sat_done", s1_done, 1);
    chk("sat_ovf_sticky", s0_ovf, 1);
    tick();

    // Zero-entry job; also clears the sticky overflow on accept.
    start(3, 5, 2, 2, 0);
    chk("cnt0_mult_valid", out_valid, 0);
    chk("cnt0_ovf_clear", s1_ovf, 0);
    tick();
    chk("cnt0_done", done, 1);
    chk("cnt0_ready", in_ready, 1);
    chk("cnt0_valid", out_valid, 0);
    tick();
    chk("cnt0_done_pulse", done, 0);

    // Reset while emitting, with overflow already set.
    in_entries = '0;
    in_entries[1*EW +: EW] = ent(0, 0, 4'd7, 4'd0, 2'd0, 2'd0);
    in_entries[2*EW +: EW] = ent(0, 0, 4'd7, 4'd0, 2'd0, 2'd0);
    start(127, 127, 2, 2, 3);
    tick();
    tick();
    tick();
    chk("rmid_pre_ovf", s1_ovf, 1);
    reset = 1'b1;
    tick();
    chk("rmid_valid", s1_valid, 0);
    chk("rmid_ready", s1_ready, 1);
    chk("rmid_ovf", s1_ovf, 0);
    chk("rmid_val", s1_val, 0);
    chk("rmid_done", s1_done, 0);
    reset = 1'b0;
    tick();
    job1(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_pe_stream.md
# delta_pe_stream

Parametrised next-generation delta processing element for the DeltaNN convolution datapath. Per accepted activation it forms one full product (input × base weight), then walks a list of kernel entries, updating the partial product with signed power-of-two deltas and emitting one output-scatter write per entry. It generalises the fixed-width PE by adding:
- a valid/ready output with backpressure;
- signed sign-controlled deltas and an optional saturation mode;
- output-boundary suppression;
- a runtime entry count.

## Interface
Parameters:
- DATA_W, 8, signed input/weight width
- ACC_W, 24, signed accumulator/output width; must be ≥ 2*DATA_W
- NUM_ENTRIES, 16, max entries per job
- SHIFT_W, 4, delta shift-amount width
- CH_W / KH_W / KW_W, 4 / 2 / 2, output-channel and kernel row/col index widths
- H_W / W_W, 6 / 6, feature-map row/col index widths
- OUT_H / OUT_W, 32 / 32, output map height/width (valid index range 0..OUT_x-1)
- SATURATE, 0, 1 = clamp on overflow, 0 = two's-complement wrap

Entry field order, MSB→LSB: {skip, neg, shift[SHIFT_W], ch[CH_W], kh[KH_W], kw[KW_W]}. ENTRY_W = 2+SHIFT_W+CH_W+KH_W+KW_W. CNT_W = $clog2(NUM_ENTRIES+1).

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  job offered
- in_ready  out  1  PE idle, job accepted when in_valid&&in_ready
- in_val  in  DATA_W  signed activation
- in_weight  in  DATA_W  signed base weight (entry 0)
- in_h / in_w  in  H_W / W_W  activation row/col
- in_count  in  CNT_W  number of entries (0..NUM_ENTRIES)
- in_entries  in  NUM_ENTRIES*ENTRY_W  packed entries, entry 0 at LSBs
- out_valid  out  1  write available
- out_ready  in  1  consumer accepts
- out_val  out  ACC_W  signed partial product for current entry
- out_ch  out  CH_W; out_h  out  H_W; out_w  out  W_W  write address
- overflow  out  1  sticky per job: an overflow occurred
- done  out  1  one-cycle pulse on job completion

## Operation
- States: IDLE, MULT, EMIT. Reset: IDLE; in_ready=1; out_valid, done, overflow, out_val, out_ch/out_h/out_w = 0.
- IDLE: in_ready=1. On accept, latch all in_* fields, clear overflow, go to MULT.
- MULT (1 cycle): out_val ← sign-extend(in_val × in_weight) to ACC_W; idx ← 0.
  - Count 0 → IDLE with done.
  - Otherwise → EMIT.
- Entry-0 delta fields are ignored. Entry k>0 term T = sext(in_val) << shift, computed at ACC_W width with upper bits truncated; T is negated if neg; T = 0 if skip.
- EMIT, entry idx: address out_ch = ch, out_h = in_h − kh, out_w = in_w − kw.
  - Suppression: the entry is suppressed when in_h < kh, or in_w < kw, or the result is ≥ OUT_H/OUT_W.
  - out_valid = 1 unless the entry is suppressed.
- Advance: advance on handshake, or unconditionally on a suppressed entry.
  - idx = count−1 → IDLE with done.
  - Otherwise idx++ and out_val ← out_val + T(entry idx+1).
- Overflow: a signed add overflow sets overflow.
  - SATURATE=1: result clamps to ±(2^(ACC_W−1)) limits (max 2^(ACC_W−1)−1, min −2^(ACC_W−1)).
  - SATURATE=0: result wraps.
- Backpressure: while out_valid && !out_ready, out_val, address and idx hold stable.
- in_entries is not sampled after accept; later changes are ignored.

## Timing
- Accept in cycle T; MULT in T+1; first out_valid in T+2.
- Throughput: 1 entry/cycle with out_ready=1. Each suppressed entry costs 1 bubble cycle (out_valid=0).
- Last handshake in cycle L → done=1 and in_ready=1 in L+1. A new job can be accepted in L+1.
- Count 0: done=1 in T+2; no out_valid.
- done is high only in the first IDLE cycle after a job.
- Reset mid-job: next cycle IDLE, all outputs at reset values, job discarded.

## Test plan
- Job 1: DATA_W=8, ACC_W=24, in_val=3, weight=5, in_h=in_w=2. Entries: e0{ch1,kh0,kw0}, e1{+shift1,kw1}, e2{neg,shift0,kh1}, e3{skip}. out_ready=1.
  - out_val 15, 21, 18, 18 in T+2..T+5.
  - Addresses (1,2,2), (1,2,1), (1,1,2), (1,2,2).
  - done in T+6.
- Backpressure: same job, out_ready=0 for 3 cycles at e1 → out_val=21 and address held 3 cycles; e3 emitted at T+8; done at T+9.
- Suppression: in_h=0, e1.kh=1 → no out_valid for e1, 1-cycle gap, e2 follows with accumulated value; done one cycle later.
- Saturation, ACC_W=16: in_val=127, weight=127 (16129), then two +shift7 entries.
  - SATURATE=1: 32385, then 32767 with overflow=1.
  - SATURATE=0: 32385, then −16895 with overflow=1.
- Count 0: accept at T → no out_valid; done=1 at T+2; in_ready=1 at T+2.
- Reset asserted during EMIT → next cycle out_valid=0, in_ready=1, overflow=0; a fresh job then runs correctly.
